// File: rtl/fetch_redirect_ctrl.sv
// rtl/fetch_redirect_ctrl.sv - fetch PC owner, redirect arbiter and reset/WFI/interrupt sequencing FSM
// Optional feature macro: IFETCH_CTRL_PERF_EN adds saturating stall/sleep performance counters.
module fetch_redirect_ctrl #(
  parameter int          NUM_REDIR   = 3,
  parameter int          PC_W        = 31,
  parameter int          FETCH_HW    = 8,
  parameter int          RESET_DELAY = 16,
  parameter int          WFI_DELAY   = 8,
  parameter logic [30:0] RESET_PC    = 31'h40000000
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           IN_en,
  input  logic                           IN_stall,
  input  logic                           IN_interruptPending,
  input  logic [NUM_REDIR-1:0]           IN_redirValid,
  input  logic [NUM_REDIR-1:0][PC_W-1:0] IN_redirPC,
  input  logic [NUM_REDIR-1:0]           IN_redirWFI,
  output logic                           OUT_fetchValid,
  output logic [PC_W-1:0]                OUT_fetchPC,
  output logic                           OUT_fetchInt,
  output logic [1:0]                     OUT_state
`ifdef IFETCH_CTRL_PERF_EN
  ,
  output logic [31:0]                    OUT_perfStall,
  output logic [31:0]                    OUT_perfSleep
`endif
);

  localparam int CNT_MAX = (RESET_DELAY > WFI_DELAY) ? RESET_DELAY : WFI_DELAY;
  localparam int CNT_W   = $clog2(CNT_MAX);
  localparam int OFF_W   = $clog2(FETCH_HW);

  typedef enum logic [1:0] {
    S_RESET_WAIT = 2'd0,
    S_RUN        = 2'd1,
    S_WFI        = 2'd2,
    S_INT_ISSUED = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [PC_W-1:0]   pc_q, pc_d;

  logic              any_redir;
  logic [PC_W-1:0]   win_pc;
  logic              win_wfi;
  logic              fetch_valid;
  logic              fetch_int;
  logic [PC_W-1:0]   pc_aligned;

  // Redirect arbitration: lowest valid index wins, so scan from the top down.
  always_comb begin
    win_pc  = '0;
    win_wfi = 1'b0;
    for (int i = NUM_REDIR - 1; i >= 0; i--) begin
      if (IN_redirValid[i]) begin
        win_pc  = IN_redirPC[i];
        win_wfi = (i != 0) && IN_redirWFI[i];
      end
    end
  end

  // Fetch issue gating, PC advance and FSM next-state; redirects take precedence over everything.
  always_comb begin
    any_redir   = |IN_redirValid;
    fetch_valid = !rst && (state_q == S_RUN) && IN_en && !IN_stall && !any_redir;
    fetch_int   = fetch_valid && IN_interruptPending;
    pc_aligned  = {pc_q[PC_W-1:OFF_W], {OFF_W{1'b0}}};

    pc_d    = pc_q;
    state_d = state_q;
    cnt_d   = cnt_q;

    if (any_redir) begin
      pc_d = win_pc;
    end else if (fetch_valid && !fetch_int) begin
      pc_d = pc_aligned + PC_W'(FETCH_HW);
    end

    if (any_redir) begin
      if (IN_redirValid[0]) begin
        state_d = S_RUN;
      end else if (win_wfi) begin
        state_d = S_WFI;
        cnt_d   = CNT_W'(WFI_DELAY - 1);
      end else begin
        case (state_q)
          S_INT_ISSUED: state_d = S_RUN;
          // Sleep states keep counting down but only leave on a redirect-free edge.
          S_WFI, S_RESET_WAIT: if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
          default: ;
        endcase
      end
    end else begin
      case (state_q)
        S_RESET_WAIT: begin
          if (cnt_q == '0) state_d = S_RUN;
          else             cnt_d   = cnt_q - 1'b1;
        end
        S_WFI: begin
          if (cnt_q == '0 || IN_interruptPending) state_d = S_RUN;
          else                                    cnt_d   = cnt_q - 1'b1;
        end
        S_RUN: begin
          if (fetch_int) state_d = S_INT_ISSUED;
        end
        default: ;
      endcase
    end
  end

  // State, countdown and PC registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_RESET_WAIT;
      cnt_q   <= CNT_W'(RESET_DELAY - 1);
      pc_q    <= PC_W'(RESET_PC);
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pc_q    <= pc_d;
    end
  end

  assign OUT_fetchValid = fetch_valid;
  assign OUT_fetchInt   = fetch_int;
  assign OUT_fetchPC    = pc_q;
  assign OUT_state      = state_q;

`ifdef IFETCH_CTRL_PERF_EN
  logic [31:0] perf_stall_q, perf_stall_d;
  logic [31:0] perf_sleep_q, perf_sleep_d;

  // Saturating performance counters: stalled-while-runnable cycles and sleeping cycles.
  always_comb begin
    perf_stall_d = perf_stall_q;
    perf_sleep_d = perf_sleep_q;
    if ((state_q == S_RUN) && IN_en && IN_stall && (perf_stall_q != 32'hFFFFFFFF))
      perf_stall_d = perf_stall_q + 32'd1;
    if (((state_q == S_WFI) || (state_q == S_RESET_WAIT)) && (perf_sleep_q != 32'hFFFFFFFF))
      perf_sleep_d = perf_sleep_q + 32'd1;
  end

  // Performance counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_stall_q <= '0;
      perf_sleep_q <= '0;
    end else begin
      perf_stall_q <= perf_stall_d;
      perf_sleep_q <= perf_sleep_d;
    end
  end

  assign OUT_perfStall = perf_stall_q;
  assign OUT_perfSleep = perf_sleep_q;
`endif

endmodule
